hazard_ctrl: RTL and testbench

// - Pipeline sequencer for the 5-stage RV32I core. Drives ctrl_src into the CONTROL decoder: 1 = zero the control word, inserting a bubble into ID/EX.
// - Generates PC / IF/ID write enables and flushes for load-use stalls, taken branches and data-memory wait states.
// - Detects a data-memory timeout; on timeout it halts the core with a sticky error flag.

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/sat_cnt32.sv | 23 ++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: opcodes, control-word layout, hazard FSM states.
// Imported by hazard_ctrl and other core blocks.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Control-word bit positions driven by the CONTROL decoder
  localparam int unsigned CW_ALUSRC   = 7;
  localparam int unsigned CW_MEMTOREG = 6;
  localparam int unsigned CW_REGWRITE = 5;
  localparam int unsigned CW_MEMREAD  = 4;
  localparam int unsigned CW_MEMWRITE = 3;
  localparam int unsigned CW_BRANCH   = 2;
  localparam int unsigned CW_ALUOP_HI = 1;
  localparam int unsigned CW_ALUOP_LO = 0;
  localparam logic [7:0]  CW_BUBBLE   = 8'b0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } hazard_state_t;

  // Load in ID/EX writes a register that the instruction in IF/ID reads
  function automatic logic load_use(input logic memread, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2);
    return memread & (rd != REG_ZERO) & ((rd == rs1) | (rd == rs2));
  endfunction

endpackage

// File: rtl/sat_cnt32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [31:0] o_cnt
);

  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch flushes, data-memory wait and timeout halt.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        ctrl_src,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        pipe_stall,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned LU_W = 2;
  localparam int unsigned TO_W = 8;

  hazard_state_t   r_state, w_state_nxt;
  hazard_state_t   r_ret_state, w_ret_state_nxt;
  logic [LU_W-1:0] r_lu_cnt, w_lu_cnt_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            r_mem_err, w_mem_err_nxt;
  logic            w_ctrl_src, w_pc_write, w_ifid_write, w_ifid_flush, w_pipe_stall;
  logic            w_mem_block, w_lu_hazard;

  assign w_mem_block = dmem_req & ~dmem_ready;
  assign w_lu_hazard = load_use(idex_memread, idex_rd, ifid_rs1, ifid_rs2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_lu_cnt    <= '0;
      r_to_cnt    <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_state_nxt;
      r_lu_cnt    <= w_lu_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_mem_err   <= w_mem_err_nxt;
    end
  end

  // Next state and same-cycle pipeline controls
  always_comb begin
    w_state_nxt     = r_state;
    w_ret_state_nxt = r_ret_state;
    w_lu_cnt_nxt    = r_lu_cnt;
    w_to_cnt_nxt    = r_to_cnt;
    w_mem_err_nxt   = r_mem_err;
    w_ctrl_src      = 1'b0;
    w_pc_write      = 1'b1;
    w_ifid_write    = 1'b1;
    w_ifid_flush    = 1'b0;
    w_pipe_stall    = 1'b0;

    case (r_state)
      ST_RUN, ST_LU_STALL: begin
        if (w_mem_block) begin
          w_pipe_stall    = 1'b1;
          w_pc_write      = 1'b0;
          w_ifid_write    = 1'b0;
          w_state_nxt     = ST_MEM_WAIT;
          w_ret_state_nxt = r_state;
          w_to_cnt_nxt    = TO_W'(1);
        end else if (r_state == ST_LU_STALL) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_ctrl_src   = 1'b1;
          if (r_lu_cnt == LU_W'(LU_STALL_CYCLES - 1)) begin
            w_state_nxt  = ST_RUN;
            w_lu_cnt_nxt = '0;
          end else begin
            w_lu_cnt_nxt = r_lu_cnt + LU_W'(1);
          end
        end else if (ex_branch_taken) begin
          w_ifid_flush = 1'b1;
          w_ctrl_src   = 1'b1;
        end else if (w_lu_hazard) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_ctrl_src   = 1'b1;
          if (LU_STALL_CYCLES > 1) begin
            w_state_nxt  = ST_LU_STALL;
            w_lu_cnt_nxt = LU_W'(1);
          end
        end
      end

      ST_MEM_WAIT: begin
        w_pipe_stall = 1'b1;
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        if (dmem_ready) begin
          w_state_nxt  = r_ret_state;
          w_to_cnt_nxt = '0;
        end else if (r_to_cnt == TO_W'(MEM_TIMEOUT)) begin
          w_state_nxt   = ST_HALT;
          w_mem_err_nxt = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end

      ST_HALT: begin
        w_pipe_stall = 1'b1;
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_ctrl_src   = 1'b1;
      end

      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Reset overrides the controls asynchronously so the pipe is frozen while rst_n is low
  assign ctrl_src   = ~rst_n | w_ctrl_src;
  assign pipe_stall = ~rst_n | w_pipe_stall;
  assign pc_write   = rst_n & w_pc_write;
  assign ifid_write = rst_n & w_ifid_write;
  assign ifid_flush = rst_n & w_ifid_flush;
  assign mem_err    = r_mem_err;

`ifdef HAZARD_PERF_EN
  sat_cnt32 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (~w_pc_write),
    .o_cnt (stall_cnt)
  );

  sat_cnt32 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_ifid_flush),
    .o_cnt (flush_cnt)
  );
`else
  assign stall_cnt = 32'b0;
  assign flush_cnt = 32'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances with different stall/timeout settings
// share stimulus; a behavioural model queues expectations, a negedge monitor compares.
module tb_hazard_ctrl;

  localparam int unsigned A_LU   = 1;
  localparam int unsigned A_TO   = 4;
  localparam int unsigned B_LU   = 2;
  localparam int unsigned B_TO   = 7;
  localparam int unsigned N_RAND = 1500;

  logic        clk;
  logic        rst_n;
  logic        idex_memread;
  logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
  logic        ex_branch_taken, dmem_req, dmem_ready;

  logic        a_ctrl_src, a_pc_write, a_ifid_write, a_ifid_flush, a_pipe_stall, a_mem_err;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_ctrl_src, b_pc_write, b_ifid_write, b_ifid_flush, b_pipe_stall, b_mem_err;
  logic [31:0] b_stall_cnt, b_flush_cnt;

  typedef struct packed {
    logic        ctrl_src;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        pipe_stall;
    logic        mem_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } obs_t;

  // Model view: is the core halted, frozen on memory, and how many bubbles are still owed
  typedef struct {
    bit              halted;
    bit              waiting;
    int              wait_len;
    int              bubbles;
    bit              err;
    longint unsigned sc;
    longint unsigned fc;
  } mdl_t;

  typedef struct {
    obs_t  e;
    string tag;
    int    cyc;
  } item_t;

  item_t qa[$];
  item_t qb[$];
  mdl_t  ma, mb;
  int    vectors, miscompares, cyc;
  bit    done;

  hazard_ctrl #(.LU_STALL_CYCLES(A_LU), .MEM_TIMEOUT(A_TO)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .ctrl_src(a_ctrl_src),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
    .pipe_stall(a_pipe_stall), .mem_err(a_mem_err), .stall_cnt(a_stall_cnt),
    .flush_cnt(a_flush_cnt)
  );

  hazard_ctrl #(.LU_STALL_CYCLES(B_LU), .MEM_TIMEOUT(B_TO)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .ctrl_src(b_ctrl_src),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
    .pipe_stall(b_pipe_stall), .mem_err(b_mem_err), .stall_cnt(b_stall_cnt),
    .flush_cnt(b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sat32(input longint unsigned v);
    logic [63:0] t;
    t = v;
    return (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
  endfunction

  task automatic model_step(input int lu, input int tmo, input bit rst, input bit haz,
                            input bit br, input bit rq, input bit rdy,
                            input mdl_t mi, output mdl_t mo, output obs_t e);
    mdl_t m;
    obs_t x;
    m = mi;
    x.ctrl_src   = 1'b0;
    x.pc_write   = 1'b1;
    x.ifid_write = 1'b1;
    x.ifid_flush = 1'b0;
    x.pipe_stall = 1'b0;
    x.mem_err    = m.err;
`ifdef HAZARD_PERF_EN
    x.stall_cnt  = sat32(m.sc);
    x.flush_cnt  = sat32(m.fc);
`else
    x.stall_cnt  = 32'd0;
    x.flush_cnt  = 32'd0;
`endif
    if (!rst) begin
      m = '{default: 0};
      x.ctrl_src = 1'b1; x.pc_write = 1'b0; x.ifid_write = 1'b0; x.pipe_stall = 1'b1;
      x.mem_err = 1'b0; x.stall_cnt = 32'd0; x.flush_cnt = 32'd0;
    end else begin
      if (m.halted) begin
        x.pipe_stall = 1'b1; x.pc_write = 1'b0; x.ifid_write = 1'b0; x.ctrl_src = 1'b1;
      end else if (m.waiting) begin
        x.pipe_stall = 1'b1; x.pc_write = 1'b0; x.ifid_write = 1'b0;
        m.wait_len++;
        if (rdy) m.waiting = 1'b0;
        else if (m.wait_len == tmo) begin
          m.halted = 1'b1;
          m.err    = 1'b1;
        end
      end else if (rq && !rdy) begin
        x.pipe_stall = 1'b1; x.pc_write = 1'b0; x.ifid_write = 1'b0;
        m.waiting  = 1'b1;
        m.wait_len = 0;
      end else if (m.bubbles > 0) begin
        x.pc_write = 1'b0; x.ifid_write = 1'b0; x.ctrl_src = 1'b1;
        m.bubbles--;
      end else if (br) begin
        x.ifid_flush = 1'b1; x.ctrl_src = 1'b1;
      end else if (haz) begin
        x.pc_write = 1'b0; x.ifid_write = 1'b0; x.ctrl_src = 1'b1;
        m.bubbles = lu - 1;
      end
      if (!x.pc_write) m.sc++;
      if (x.ifid_flush) m.fc++;
    end
    mo = m;
    e  = x;
  endtask

  task automatic drive(input string t, input bit rst, input bit mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input bit br,
                       input bit rq, input bit rdy);
    item_t ia, ib;
    bit    haz;
    @(posedge clk);
    #1;
    rst_n = rst; idex_memread = mr; idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
    ex_branch_taken = br; dmem_req = rq; dmem_ready = rdy;
    haz = mr && (rd != 5'd0) && ((rd == r1) || (rd == r2));
    model_step(int'(A_LU), int'(A_TO), rst, haz, br, rq, rdy, ma, ma, ia.e);
    model_step(int'(B_LU), int'(B_TO), rst, haz, br, rq, rdy, mb, mb, ib.e);
    ia.tag = t; ia.cyc = cyc;
    ib.tag = t; ib.cyc = cyc;
    qa.push_back(ia);
    qb.push_back(ib);
    cyc++;
  endtask

  task automatic idle(input string t, input int n);
    for (int k = 0; k < n; k++) drive(t, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string dut, input item_t it, input obs_t act);
    vectors++;
    if (act !== it.e) begin
      miscompares++;
      $display("FAIL %s %s cyc=%0d ctrl/pc/ifw/flush/stall/err got %b%b%b%b%b%b exp %b%b%b%b%b%b stall_cnt got %0d exp %0d flush_cnt got %0d exp %0d",
               dut, it.tag, it.cyc,
               act.ctrl_src, act.pc_write, act.ifid_write, act.ifid_flush, act.pipe_stall, act.mem_err,
               it.e.ctrl_src, it.e.pc_write, it.e.ifid_write, it.e.ifid_flush, it.e.pipe_stall, it.e.mem_err,
               act.stall_cnt, it.e.stall_cnt, act.flush_cnt, it.e.flush_cnt);
    end
  endtask

  // Monitor: one expectation per DUT per cycle, sampled mid-cycle
  always @(negedge clk) begin
    obs_t  aa, bb;
    item_t it;
    aa = {a_ctrl_src, a_pc_write, a_ifid_write, a_ifid_flush, a_pipe_stall, a_mem_err,
          a_stall_cnt, a_flush_cnt};
    bb = {b_ctrl_src, b_pc_write, b_ifid_write, b_ifid_flush, b_pipe_stall, b_mem_err,
          b_stall_cnt, b_flush_cnt};
    if (qa.size() != 0) begin
      it = qa.pop_front();
      check("dutA", it, aa);
    end
    if (qb.size() != 0) begin
      it = qb.pop_front();
      check("dutB", it, bb);
    end
    if (done) begin
      if (qa.size() != 0 || qb.size() != 0) begin
        miscompares++;
        $display("FAIL queue_drain left A=%0d B=%0d required 0", qa.size(), qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    int burst;
    bit rst, mr, br, rq, rdy;
    logic [4:0] rd, r1, r2;
    vectors = 0; miscompares = 0; cyc = 0; done = 1'b0; burst = 0;
    ma = '{default: 0};
    mb = '{default: 0};
    rst_n = 1'b0; idex_memread = 1'b0; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;

    for (int k = 0; k < 2; k++) drive("reset", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle("idle", 2);

    drive("lu_rs2", 1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b1);
    idle("after_lu", 3);
    drive("lu_rd0", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle("idle", 1);
    drive("lu_vs_branch", 1'b1, 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b1);
    idle("idle", 2);

    drive("mwait", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) drive("mwait_br", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    drive("mwait_rel", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    drive("br_after_rel", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    idle("idle", 2);

    drive("lu_then_wait", 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("wait_in_lu", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive("wait_in_lu_rel", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle("lu_resume", 3);

    for (int k = 0; k < 4; k++) drive("to_edge", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive("to_edge_rdy", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle("idle", 2);

    for (int k = 0; k < 12; k++) drive("timeout", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) drive("halted", 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
    drive("halt_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle("post_halt", 2);

    drive("lu_pre_rst", 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1);
    drive("rst_in_lu", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle("post_rst", 2);

    for (int i = 0; i < int'(N_RAND); i++) begin
      rst = ($urandom_range(0, 99) > 2);
      if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(2, 10);
      rdy = (burst > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (burst > 0) burst--;
      mr = ($urandom_range(0, 2) == 0);
      rd = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      br = ($urandom_range(0, 4) == 0);
      rq = ($urandom_range(0, 2) == 0) || (burst > 0);
      drive("random", rst, mr, rd, r1, r2, br, rq, rdy);
    end

    done = 1'b1;
  end

endmodule
